// File: rtl/s4_maxpool_writer_if.sv
// Port bundle for the S4 max-pool writer: C3 pixel stream in, F4 write port out.
// c3 handshake: a pixel transfers on a rising edge where c3_valid && c3_ready; c3_data is held by the source while c3_valid is high and unaccepted.
interface s4_maxpool_writer_if #(
  parameter int DW = 16,
  parameter int CH = 16,
  parameter int AW = 7
);
  logic               start;
  logic               c3_valid;
  logic               c3_ready;
  logic [CH*DW-1:0]   c3_data;
  logic               f4_wr_en;
  logic [AW-1:0]      f4_waddr;
  logic [CH*DW-1:0]   f4_wdata;
  logic               busy;
  logic               done;
  logic [1:0]         dbg_state;

  modport master (
    output start, c3_valid, c3_data,
    input  c3_ready, f4_wr_en, f4_waddr, f4_wdata, busy, done, dbg_state
  );

  modport slave (
    input  start, c3_valid, c3_data,
    output c3_ready, f4_wr_en, f4_waddr, f4_wdata, busy, done, dbg_state
  );
endinterface

// File: rtl/s4_maxpool_writer.sv
// 2x2 stride-2 max pooling over a raster C3 stream, writing one pooled
// 16-lane word per output pixel into the F4 RAM write port.
module s4_maxpool_writer #(
  parameter int DW   = 16,
  parameter int CH   = 16,
  parameter int IN_W = 10,
  parameter int IN_H = 10,
  parameter int AW   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  s4_maxpool_writer_if.slave bus
);
  localparam int LW   = CH * DW;
  localparam int CW   = $clog2(IN_W);
  localparam int RW   = $clog2(IN_H);
  localparam int NOUT = IN_W * IN_H / 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [AW-1:0]   r_cnt;
  logic [LW-1:0]   r_hreg;
  logic [LW-1:0]   r_linebuf [IN_W/2];
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_wr_en;
  logic [AW-1:0]   r_waddr;
  logic [LW-1:0]   r_wdata;

  logic            w_acc;
  logic            w_last_col;
  logic            w_last_px;
  logic [LW-1:0]   w_hmax;
  logic [LW-1:0]   w_pool;

  function automatic logic [LW-1:0] lane_max(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [LW-1:0] res;
    res = '0;
    for (int k = 0; k < CH; k++) begin
      res[k*DW +: DW] = ($signed(a[k*DW +: DW]) > $signed(b[k*DW +: DW])) ? a[k*DW +: DW] : b[k*DW +: DW];
    end
    return res;
  endfunction

  assign w_acc      = bus.c3_valid && r_ready;
  assign w_last_col = (r_col == CW'(IN_W - 1));
  assign w_last_px  = w_last_col && (r_row == RW'(IN_H - 1));

  always_comb begin
    w_hmax = lane_max(r_hreg, bus.c3_data);
    w_pool = lane_max(r_linebuf[r_col[CW-1:1]], w_hmax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
      r_hreg  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_col   <= '0;
            r_row   <= '0;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (w_acc) begin
            if (!r_col[0]) begin
              r_hreg <= bus.c3_data;
            end else if (r_row[0]) begin
              r_wr_en <= 1'b1;
              r_wdata <= w_pool;
              r_waddr <= r_cnt;
              r_cnt   <= r_cnt + AW'(1);
            end
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
            // Input closes as soon as the final pixel is taken; the last write drains next cycle.
            if (w_last_px) r_ready <= 1'b0;
          end
          if (r_wr_en && (r_waddr == AW'(NOUT - 1))) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line buffer holds even-row horizontal maxima; its content needs no reset.
  always_ff @(posedge clk) begin
    if (w_acc && r_col[0] && !r_row[0]) begin
      r_linebuf[r_col[CW-1:1]] <= w_hmax;
    end
  end

  assign bus.c3_ready  = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.f4_wr_en  = r_wr_en;
  assign bus.f4_waddr  = r_waddr;
  assign bus.f4_wdata  = r_wdata;
  assign bus.dbg_state = r_state;
endmodule
